// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the jtframe download router and its write FIFO.
package jtframe_dwnld_pkg;

    localparam int BA_W    = 2;
    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 16;
    localparam int MASK_W  = 2;
    localparam int ENTRY_W = 42;

    // Active-low byte enables: bit0 = even byte lane, bit1 = odd byte lane
    localparam logic [1:0] MASK_BOTH = 2'b00;
    localparam logic [1:0] MASK_EVEN = 2'b10;
    localparam logic [1:0] MASK_ODD  = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    localparam logic [24:0] PROM_NONE = ~25'd0;

    typedef struct packed {
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } entry_t;

    function automatic entry_t make_entry(input logic [1:0] ba, input logic [21:0] addr,
                                          input logic [15:0] data, input logic [1:0] mask);
        entry_t e;
        e.ba   = ba;
        e.addr = addr;
        e.data = data;
        e.mask = mask;
        return e;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_pack_if.sv
// SDRAM programming port between the download router (master) and jtframe_sdram (slave).
interface jtframe_dwnld_pack_if;
    import jtframe_dwnld_pkg::*;

    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [MASK_W-1:0] prog_mask;
    logic [BA_W-1:0]   prog_ba;
    logic              prog_we;
    logic              prog_rd;
    logic              sdram_ack;

    modport master (
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        input  sdram_ack
    );

    modport slave (
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        output sdram_ack
    );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO for pending SDRAM writes; pop on empty and push on full
// (unless popped the same cycle) are ignored.
module jtframe_dwnld_fifo #(
    parameter int AW = 2,
    parameter int W  = 42
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Download router: drops the file header, sends the PROM region to prom_*, and packs
// byte pairs into 16-bit SDRAM writes queued in a FIFO. Byte lanes swap with JTFRAME_DWNLD_SWAP_EN.
module jtframe_dwnld_pack
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] HEADER     = 25'd0,
    parameter logic [24:0] PROM_START = ~25'd0,
    parameter logic [24:0] BA1_START  = ~25'd0,
    parameter logic [24:0] BA2_START  = ~25'd0,
    parameter logic [24:0] BA3_START  = ~25'd0,
    parameter int          FIFO_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 downloading,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_data,
    input  logic                 ioctl_wr,
    jtframe_dwnld_pack_if.master sdram,
    output logic [21:0]          prom_addr,
    output logic [7:0]           prom_data,
    output logic                 prom_we,
    output logic                 dwnld_busy,
    output logic                 overflow
);

`ifdef JTFRAME_DWNLD_SWAP_EN
    localparam logic [1:0] EVEN_ONLY = MASK_ODD;
    localparam logic [1:0] ODD_ONLY  = MASK_EVEN;
    function automatic logic [15:0] pair_word(input logic [7:0] even_b, input logic [7:0] odd_b);
        return {even_b, odd_b};
    endfunction
`else
    localparam logic [1:0] EVEN_ONLY = MASK_EVEN;
    localparam logic [1:0] ODD_ONLY  = MASK_ODD;
    function automatic logic [15:0] pair_word(input logic [7:0] even_b, input logic [7:0] odd_b);
        return {odd_b, even_b};
    endfunction
`endif

    logic        hdr_borrow_s;
    logic [24:0] eff_s;
    logic [24:0] prom_off_s;
    logic [24:0] off_s;
    logic [24:0] local_s;
    logic [1:0]  ba_s;
    logic [21:0] word_s;
    logic        accept_s;
    logic        prom_hit_s;
    logic        dl_rise_s;
    logic        dl_fall_s;
    logic        push_s;
    logic        pop_s;
    entry_t      push_entry_s;
    entry_t      head_s;
    logic [ENTRY_W-1:0] fifo_dout_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        unused_s;

    logic        dl_q;
    logic        hold_vld_q,  hold_vld_d;
    logic [1:0]  hold_ba_q,   hold_ba_d;
    logic [21:0] hold_word_q, hold_word_d;
    logic [7:0]  hold_lo_q,   hold_lo_d;
    logic        prog_we_q,   prog_we_d;
    logic        overflow_q,  overflow_d;
    logic        prom_we_q;
    logic [21:0] prom_addr_q;
    logic [7:0]  prom_data_q;

    // Header removal via borrow so a zero HEADER needs no always-true compare
    assign {hdr_borrow_s, eff_s} = {1'b0, ioctl_addr} - {1'b0, HEADER};
    assign accept_s   = ioctl_wr && downloading && !hdr_borrow_s;
    assign prom_hit_s = (PROM_START != PROM_NONE) && (eff_s >= PROM_START);
    assign prom_off_s = eff_s - PROM_START;
    assign local_s    = eff_s - off_s;
    assign word_s     = local_s[22:1];
    assign dl_rise_s  = downloading && !dl_q;
    assign dl_fall_s  = !downloading && dl_q;
    assign pop_s      = sdram.sdram_ack && prog_we_q;
    assign unused_s   = ^{local_s[24:23], prom_off_s[24:22]};

    // Bank select: highest enabled bank whose start is at or below eff
    always_comb begin
        ba_s  = 2'd0;
        off_s = 25'd0;
        if ((BA3_START != PROM_NONE) && (eff_s >= BA3_START)) begin
            ba_s  = 2'd3;
            off_s = BA3_START;
        end else if ((BA2_START != PROM_NONE) && (eff_s >= BA2_START)) begin
            ba_s  = 2'd2;
            off_s = BA2_START;
        end else if ((BA1_START != PROM_NONE) && (eff_s >= BA1_START)) begin
            ba_s  = 2'd1;
            off_s = BA1_START;
        end else begin
            ba_s  = 2'd0;
            off_s = 25'd0;
        end
    end

    // Byte packing and hold register next state; at most one push per cycle
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '0;
        hold_vld_d   = hold_vld_q;
        hold_ba_d    = hold_ba_q;
        hold_word_d  = hold_word_q;
        hold_lo_d    = hold_lo_q;
        if (accept_s && !prom_hit_s) begin
            if (!local_s[0]) begin
                if (hold_vld_q) begin
                    push_s       = 1'b1;
                    push_entry_s = make_entry(hold_ba_q, hold_word_q, {hold_lo_q, hold_lo_q}, EVEN_ONLY);
                end else begin
                    push_s       = 1'b0;
                end
                hold_vld_d  = 1'b1;
                hold_ba_d   = ba_s;
                hold_word_d = word_s;
                hold_lo_d   = ioctl_data;
            end else if (hold_vld_q && (hold_ba_q == ba_s) && (hold_word_q == word_s)) begin
                push_s       = 1'b1;
                push_entry_s = make_entry(ba_s, word_s, pair_word(hold_lo_q, ioctl_data), MASK_BOTH);
                hold_vld_d   = 1'b0;
            end else begin
                push_s       = 1'b1;
                push_entry_s = make_entry(ba_s, word_s, {ioctl_data, ioctl_data}, ODD_ONLY);
            end
        end else if (dl_fall_s && hold_vld_q) begin
            push_s       = 1'b1;
            push_entry_s = make_entry(hold_ba_q, hold_word_q, {hold_lo_q, hold_lo_q}, EVEN_ONLY);
            hold_vld_d   = 1'b0;
        end else begin
            push_s       = 1'b0;
        end
    end

    // Write request and sticky overflow next state
    always_comb begin
        prog_we_d  = !fifo_empty_s && !pop_s;
        overflow_d = overflow_q;
        if (push_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (dl_rise_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q        <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_ba_q   <= 2'd0;
            hold_word_q <= 22'd0;
            hold_lo_q   <= 8'd0;
            prog_we_q   <= 1'b0;
            overflow_q  <= 1'b0;
            prom_we_q   <= 1'b0;
            prom_addr_q <= 22'd0;
            prom_data_q <= 8'd0;
        end else begin
            dl_q        <= downloading;
            hold_vld_q  <= hold_vld_d;
            hold_ba_q   <= hold_ba_d;
            hold_word_q <= hold_word_d;
            hold_lo_q   <= hold_lo_d;
            prog_we_q   <= prog_we_d;
            overflow_q  <= overflow_d;
            prom_we_q   <= accept_s && prom_hit_s;
            if (accept_s && prom_hit_s) begin
                prom_addr_q <= prom_off_s[21:0];
                prom_data_q <= ioctl_data;
            end
        end
    end

    jtframe_dwnld_fifo #(
        .AW (FIFO_AW),
        .W  (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Bus idles at zero data with both lanes disabled whenever no request is pending
    assign head_s          = entry_t'(fifo_dout_s);
    assign sdram.prog_we   = prog_we_q;
    assign sdram.prog_rd   = 1'b0;
    assign sdram.prog_addr = prog_we_q ? head_s.addr : 22'd0;
    assign sdram.prog_data = prog_we_q ? head_s.data : 16'd0;
    assign sdram.prog_mask = prog_we_q ? head_s.mask : MASK_NONE;
    assign sdram.prog_ba   = prog_we_q ? head_s.ba   : 2'd0;

    assign prom_we    = prom_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_data  = prom_data_q;
    assign overflow   = overflow_q;
    assign dwnld_busy = downloading || hold_vld_q || !fifo_empty_s;

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed bench for jtframe_dwnld_pack: HEADER=0x40, banks at 0x100/0x200/0x300, PROM at 0x8000.
module tb_jtframe_dwnld_pack;

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prom_addr;
    logic [7:0]  prom_data;
    logic        prom_we;
    logic        dwnld_busy;
    logic        overflow;
    int          n_vec;
    int          n_miss;

    jtframe_dwnld_pack_if sd();

    jtframe_dwnld_pack #(
        .HEADER     (25'h40),
        .PROM_START (25'h8000),
        .BA1_START  (25'h100),
        .BA2_START  (25'h200),
        .BA3_START  (25'h300),
        .FIFO_AW    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .sdram       (sd.master),
        .prom_addr   (prom_addr),
        .prom_data   (prom_data),
        .prom_we     (prom_we),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [1:0] ba, input logic [21:0] addr,
                               input logic [15:0] data, input logic [1:0] mask);
        for (int i = 0; i < 20 && !sd.prog_we; i++) @(negedge clk);
        chk({tag, "_we"},   64'(sd.prog_we),   64'(1'b1));
        chk({tag, "_ba"},   64'(sd.prog_ba),   64'(ba));
        chk({tag, "_addr"}, 64'(sd.prog_addr), 64'(addr));
        chk({tag, "_data"}, 64'(sd.prog_data), 64'(data));
        chk({tag, "_mask"}, 64'(sd.prog_mask), 64'(mask));
    endtask

    task automatic ack_pulse(input string tag);
        sd.sdram_ack = 1'b1;
        @(negedge clk);
        sd.sdram_ack = 1'b0;
        chk({tag, "_gap"}, 64'(sd.prog_we), 64'(1'b0));
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        downloading  = 1'b0;
        ioctl_addr   = 25'd0;
        ioctl_data   = 8'd0;
        ioctl_wr     = 1'b0;
        sd.sdram_ack = 1'b0;
        idle(3);
        chk("rst_we",   64'(sd.prog_we),   64'(1'b0));
        chk("rst_mask", 64'(sd.prog_mask), 64'(2'b11));
        chk("rst_rd",   64'(sd.prog_rd),   64'(1'b0));
        chk("rst_prom", 64'(prom_we),      64'(1'b0));
        chk("rst_busy", 64'(dwnld_busy),   64'(1'b0));
        chk("rst_ovf",  64'(overflow),     64'(1'b0));
        rst_n = 1'b1;
        idle(2);

        // Pair packing: eff 0/1
        downloading = 1'b1;
        wr_byte(25'h40, 8'h11);
        wr_byte(25'h41, 8'h22);
        expect_word("pair", 2'd0, 22'd0, 16'h2211, 2'b00);
        idle(3);
        ack_pulse("pair");

        // Header bytes are discarded, including even ones that would load the hold
        for (int i = 0; i < 64; i++) wr_byte(25'(i), 8'(i));
        idle(4);
        chk("hdr_we", 64'(sd.prog_we), 64'(1'b0));
        downloading = 1'b0;
        idle(4);
        chk("hdr_we_end", 64'(sd.prog_we),  64'(1'b0));
        chk("hdr_busy",   64'(dwnld_busy),  64'(1'b0));

        // Bank 1 and bank 3 odd-only writes
        downloading = 1'b1;
        wr_byte(25'h141, 8'hAA);
        expect_word("ba1", 2'd1, 22'd0, 16'hAAAA, 2'b01);
        ack_pulse("ba1");
        wr_byte(25'h345, 8'h3C);
        expect_word("ba3", 2'd3, 22'd2, 16'h3C3C, 2'b01);
        ack_pulse("ba3");

        // PROM routing: eff 0x8003
        wr_byte(25'h8043, 8'h5C);
        chk("prom_we1",  64'(prom_we),   64'(1'b1));
        chk("prom_addr", 64'(prom_addr), 64'(22'd3));
        chk("prom_data", 64'(prom_data), 64'(8'h5C));
        idle(1);
        chk("prom_we0",  64'(prom_we),   64'(1'b0));
        idle(3);
        chk("prom_nosd", 64'(sd.prog_we), 64'(1'b0));

        // Even byte replacing a held even byte, then flush of the new hold
        wr_byte(25'h60, 8'h12);
        wr_byte(25'h64, 8'h34);
        expect_word("repl", 2'd0, 22'h10, 16'h1212, 2'b10);
        ack_pulse("repl");
        downloading = 1'b0;
        expect_word("repl_fl", 2'd0, 22'h12, 16'h3434, 2'b10);
        ack_pulse("repl_fl");
        chk("repl_busy", 64'(dwnld_busy), 64'(1'b0));

        // Backpressure: ten bytes at eff 0x10.. with ack held low
        idle(1);
        downloading = 1'b1;
        for (int i = 0; i < 10; i++) wr_byte(25'h50 + 25'(i), 8'(8'hA0 + i));
        chk("bp_ovf", 64'(overflow),   64'(1'b1));
        chk("bp_we",  64'(sd.prog_we), 64'(1'b1));
        for (int k = 0; k < 4; k++) begin
            expect_word($sformatf("bp%0d", k), 2'd0, 22'(8 + k),
                        {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)}, 2'b00);
            ack_pulse($sformatf("bp%0d", k));
        end
        idle(4);
        chk("bp_drained", 64'(sd.prog_we), 64'(1'b0));
        downloading = 1'b0;
        idle(2);
        chk("bp_ovf_sticky", 64'(overflow), 64'(1'b1));
        downloading = 1'b1;
        idle(2);
        chk("bp_ovf_clr", 64'(overflow), 64'(1'b0));

        // Flush of a lone even byte at eff 6 when downloading falls
        wr_byte(25'h46, 8'h77);
        idle(3);
        chk("fl_hold_we", 64'(sd.prog_we), 64'(1'b0));
        downloading = 1'b0;
        expect_word("fl", 2'd0, 22'd3, 16'h7777, 2'b10);
        idle(2);
        chk("fl_busy_hi", 64'(dwnld_busy), 64'(1'b1));
        ack_pulse("fl");
        chk("fl_busy_lo", 64'(dwnld_busy), 64'(1'b0));

        // Reset mid-drain with three entries queued
        downloading = 1'b1;
        for (int i = 0; i < 6; i++) wr_byte(25'h60 + 25'(i), 8'(i));
        expect_word("rd", 2'd0, 22'h10, 16'h0100, 2'b00);
        rst_n       = 1'b0;
        downloading = 1'b0;
        #1;
        chk("rd_we",   64'(sd.prog_we),   64'(1'b0));
        chk("rd_mask", 64'(sd.prog_mask), 64'(2'b11));
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        chk("rd_we_after", 64'(sd.prog_we), 64'(1'b0));
        chk("rd_busy",     64'(dwnld_busy), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/jtframe_dwnld_pack.md
Name: jtframe_dwnld_pack

Overview:
- Successor download router between the ioctl byte stream and jtframe_sdram programming port.
- Packs consecutive byte pairs into single 16-bit writes and supports up to four SDRAM banks.
- Skips a parametrised file header and splits off a PROM region.
- Buffers pending SDRAM writes in a small FIFO, so ioctl bursts never stall on sdram_ack latency.

Parameters:
HEADER, 0, bytes at file start discarded; eff = ioctl_addr - HEADER
PROM_START, ~25'd0, eff address where PROM region begins; all-ones = no PROM
BA1_START, ~25'd0, eff address of bank 1 start; all-ones = unused
BA2_START, ~25'd0, eff address of bank 2 start; all-ones = unused
BA3_START, ~25'd0, eff address of bank 3 start; all-ones = unused
FIFO_AW, 2, log2 FIFO depth (depth 4 by default)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
downloading  in  1  download window
ioctl_addr  in  25  byte address
ioctl_data  in  8  byte data
ioctl_wr  in  1  byte strobe, single cycle
prog_addr  out  22  SDRAM word address within bank
prog_data  out  16  write word
prog_mask  out  2  active-low byte enables; bit0 = even byte, bit1 = odd byte
prog_ba  out  2  SDRAM bank
prog_we  out  1  write request
prog_rd  out  1  tied 0
sdram_ack  in  1  one-cycle write accept
prom_addr  out  22  PROM byte address (eff - PROM_START)
prom_data  out  8  PROM byte
prom_we  out  1  one-cycle PROM write strobe
dwnld_busy  out  1  downloading, or holding a byte, or FIFO non-empty
overflow  out  1  sticky: byte lost to full FIFO

Behaviour:
- Reset: all outputs 0 except prog_mask = 2'b11; FIFO empty; hold register empty; overflow cleared.
- Byte accept: happens when ioctl_wr && downloading.
  - Bytes with ioctl_addr < HEADER are dropped.
  - eff >= PROM_START (PROM enabled): prom_addr/prom_data registered, prom_we high for exactly the next cycle; FIFO untouched.
- Bank/offset:
  - Bank is the highest enabled BAn_START <= eff, else bank 0. Offset = that start (0 for bank 0).
  - Local = eff - offset; word address = local[22:1].
- Packing (SDRAM bytes):
  - Even local byte: stored in hold register {ba, word, lo}.
  - Odd byte with same ba and word as a valid hold: push {ba, word, {odd, even}, 2'b00}; hold cleared.
  - Odd byte otherwise: push {ba, word, {odd, odd}, 2'b01}.
  - Even byte while hold is valid: push the old hold as {lo, lo}, mask 2'b10, and load the new hold in the same cycle.
  - downloading falling edge with hold valid: push the hold (mask 2'b10) on the next cycle.
- FIFO:
  - The head entry drives prog_addr/data/mask/ba.
  - prog_we rises one cycle after the FIFO becomes non-empty and stays high until sdram_ack.
  - sdram_ack pops the head and forces prog_we low for exactly one cycle; it reasserts the cycle after if entries remain.
  - Simultaneous push and pop are legal at any occupancy, including full.
  - Push while full without a same-cycle pop: entry dropped, overflow set.
  - overflow clears only on a downloading rising edge.
  - sdram_ack while prog_we is low is ignored.
- End of download: the FIFO keeps draining after downloading falls. dwnld_busy falls the cycle after the last ack.
- Reset mid-operation: everything discarded immediately, no flush.

Optional Feature:
- JTFRAME_DWNLD_SWAP_EN defined: byte lanes swapped on the SDRAM path. Even byte goes to prog_data[15:8] with mask bit1; odd byte goes to [7:0] with mask bit0. Pair mask stays 2'b00. PROM path is unaffected.
- Not defined: lanes exactly as in Behaviour.

Decomposition:
- Package jtframe_dwnld_pkg holds:
  - entry field widths: BA=2, ADDR=22, DATA=16, MASK=2, ENTRY_W=42
  - mask constants: MASK_BOTH=2'b00, MASK_EVEN=2'b10, MASK_ODD=2'b01
  - PROM_NONE = ~25'd0
- One sub-module: jtframe_dwnld_fifo, a synchronous FIFO parametrised by FIFO_AW and width.
  - Ports: push, pop, din, dout, empty, full.
  - Pop on empty and push on full are ignored internally.

Test Plan:
- Pair packing: HEADER=0, bytes 0x11@0, 0x22@1, sdram_ack 3 cycles after prog_we → one write: prog_addr=0, prog_data=16'h2211, prog_mask=2'b00, prog_ba=0.
- Header/bank split: HEADER=0x40, BA1_START=0x100; byte 0xAA at ioctl_addr 0x141 → prog_ba=1, prog_addr=0, prog_data=16'hAAAA, mask 2'b01; bytes at 0x00–0x3F produce no writes.
- PROM routing: PROM_START=0x8000; byte 0x5C at eff 0x8003 → prom_we high exactly one cycle, prom_addr=3, prom_data=8'h5C; prog_we stays 0.
- Backpressure: FIFO_AW=2, ten bytes at consecutive addresses with sdram_ack held low → 4 entries queued, overflow=1, writes stall. Releasing ack pulses drains 4 words, and prog_we shows a one-cycle gap after each ack.
- Flush: single even byte 0x77@6, then downloading falls → word 3, data 16'h7777, mask 2'b10 pushed. dwnld_busy stays high until that ack, then falls the next cycle.
- Reset mid-drain: rst_n low with 3 entries queued → prog_we=0 and mask 2'b11 immediately. After release, no writes occur and dwnld_busy=0.
